// File: rtl/li_upsampler_pkg.sv
// Shared defaults, state encoding and width helper for the linear-interpolating upsampler.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package li_upsampler_pkg;

    localparam int LI_WIDTH_DEF      = 18;
    localparam int LI_LOG2_RATIO_DEF = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

    // The accumulator holds a sample scaled by 2^log2_ratio plus one guard bit.
    function automatic int acc_width(input int width, input int log2_ratio);
        return width + log2_ratio + 1;
    endfunction

endpackage

// File: rtl/li_step_acc.sv
// Accumulator/slope pair for one interpolation segment; step_val is the floored next point.
// Latency: step_val is combinational from the registered acc/delta (one cycle after load/step).
// Backpressure: none; load and step are one-cycle commands, load wins over step.
module li_step_acc
    import li_upsampler_pkg::*;
#(
    parameter int WIDTH      = LI_WIDTH_DEF,
    parameter int LOG2_RATIO = LI_LOG2_RATIO_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] curr_in,
    input  logic [WIDTH-1:0] sample_in,
    output logic [WIDTH-1:0] step_val
);

    localparam int AW = acc_width(WIDTH, LOG2_RATIO);

    logic signed [AW-1:0] acc_q;
    logic signed [AW-1:0] acc_d;
    logic signed [AW-1:0] acc_next;
    logic signed [WIDTH:0] delta_q;
    logic signed [WIDTH:0] delta_d;

    // Next accumulator point; slicing off the fraction bits of a two's complement value is a floor shift.
    always_comb begin
        acc_next = acc_q + $signed({{LOG2_RATIO{delta_q[WIDTH]}}, delta_q});
        step_val = acc_next[WIDTH+LOG2_RATIO-1:LOG2_RATIO];
    end

    // Load starts a segment at the old sample with the full-precision slope; step walks along it.
    always_comb begin
        acc_d   = acc_q;
        delta_d = delta_q;
        if (load) begin
            acc_d   = $signed({curr_in[WIDTH-1], curr_in, {LOG2_RATIO{1'b0}}});
            delta_d = $signed({sample_in[WIDTH-1], sample_in}) - $signed({curr_in[WIDTH-1], curr_in});
        end else if (step) begin
            acc_d   = acc_next;
        end
    end

    // Accumulator and slope registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            acc_q   <= '0;
            delta_q <= '0;
        end else begin
            acc_q   <= acc_d;
            delta_q <= delta_d;
        end
    end

endmodule

// File: rtl/li_upsampler.sv
// Linear interpolator: each rising ready_in loads a sample, each clken_out emits one interpolated point.
// Latency: sample_out/out_valid register one cycle after clken_out; slip one cycle after the early load.
// Backpressure: none; upstream samples are never stalled, an early sample restarts the segment (slip).
module li_upsampler
    import li_upsampler_pkg::*;
#(
    parameter int WIDTH      = LI_WIDTH_DEF,
    parameter int LOG2_RATIO = LI_LOG2_RATIO_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             ready_in,
    input  logic             clken_out,
    output logic [WIDTH-1:0] sample_out,
    output logic             out_valid,
    output logic             slip,
    output logic             busy
);

    localparam logic [LOG2_RATIO-1:0] PHASE_LAST = '1;

    logic                  ready_q;
    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic [WIDTH-1:0]      curr_q;
    logic [WIDTH-1:0]      curr_d;
    logic [LOG2_RATIO-1:0] phase_q;
    logic [LOG2_RATIO-1:0] phase_d;
    logic [WIDTH-1:0]      sample_out_q;
    logic [WIDTH-1:0]      sample_out_d;
    logic                  out_valid_q;
    logic                  out_valid_d;
    logic                  slip_q;
    logic                  slip_d;
    logic                  new_evt;
    logic                  step;
    logic [WIDTH-1:0]      step_val;

    // A level held high never retriggers; ready_q resets high so a level present at release is ignored.
    assign new_evt = ready_in & ~ready_q;
    // A pending load takes priority over the interpolation step.
    assign step    = clken_out && (state_q == ST_RUN) && !new_evt;

    li_step_acc #(
        .WIDTH      (WIDTH),
        .LOG2_RATIO (LOG2_RATIO)
    ) u_step_acc (
        .clock     (clock),
        .reset     (reset),
        .load      (new_evt),
        .step      (step),
        .curr_in   (curr_q),
        .sample_in (sample_in),
        .step_val  (step_val)
    );

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: every new sample advances toward RUN; the last step of a segment parks in HOLD.
    always_comb begin
        state_d = state_q;
        if (new_evt) begin
            case (state_q)
                ST_IDLE: state_d = ST_PRIME;
                default: state_d = ST_RUN;
            endcase
        end else if (step && (phase_q == PHASE_LAST)) begin
            state_d = ST_HOLD;
        end
    end

    // Output decode: emit on every strobe outside IDLE; a colliding load emits the segment start.
    always_comb begin
        sample_out_d = sample_out_q;
        out_valid_d  = 1'b0;
        slip_d       = new_evt && (state_q == ST_RUN) && (phase_q != '0);
        curr_d       = new_evt ? sample_in : curr_q;
        phase_d      = phase_q;
        if (new_evt) begin
            phase_d = '0;
        end else if (step) begin
            phase_d = phase_q + 1'b1;
        end
        if (clken_out && (state_q != ST_IDLE)) begin
            out_valid_d  = 1'b1;
            sample_out_d = step ? step_val : curr_q;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q      <= 1'b1;
            curr_q       <= '0;
            phase_q      <= '0;
            sample_out_q <= '0;
            out_valid_q  <= 1'b0;
            slip_q       <= 1'b0;
        end else begin
            ready_q      <= ready_in;
            curr_q       <= curr_d;
            phase_q      <= phase_d;
            sample_out_q <= sample_out_d;
            out_valid_q  <= out_valid_d;
            slip_q       <= slip_d;
        end
    end

    assign sample_out = sample_out_q;
    assign out_valid  = out_valid_q;
    assign slip       = slip_q;
    assign busy       = (state_q == ST_RUN);

endmodule
